// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_t;

  // Widest pattern the mask helper supports; callers cast down to their own width.
  localparam int unsigned MASK_W = 32;

  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_shift_window.sv
// History shift register plus a fill counter that saturates at PAT_W.
// Exposes next-cycle values so the caller can compare the bit being sampled.
module seq_shift_window #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_fill_clr,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [PAT_W-1:0] o_hist_next,
  output logic [LEN_W-1:0] o_fill_next
);

  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;

  assign o_hist_next = {r_hist[PAT_W-2:0], i_bit};
  assign o_fill_next = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_hist <= o_hist_next;
      r_fill <= i_fill_clr ? '0 : o_fill_next;
    end
  end

endmodule

// File: rtl/param_sequence_detector.sv
// Runtime-programmable serial pattern detector with overlap control and a
// saturating match counter; one registered pulse per match.
module param_sequence_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             in_valid,
  input  logic             in,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  state_t           r_state;
  state_t           w_state_next;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic             r_overlap;
  logic             r_out;
  logic [CNT_W-1:0] r_cnt;

  logic [LEN_W-1:0] w_len_clamped;
  logic [PAT_W-1:0] w_mask;
  logic [PAT_W-1:0] w_hist_next;
  logic [LEN_W-1:0] w_fill_next;
  logic             w_hit;
  logic             w_match;
  logic             w_shift;
  logic             w_fill_clr;
  logic             w_clr;

  assign w_len_clamped = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
  assign w_mask        = PAT_W'(len_mask(32'(r_len)));
  assign w_hit         = (((w_hist_next ^ r_pat) & w_mask) == '0);

  seq_shift_window #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_window (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_clr),
    .i_fill_clr  (w_fill_clr),
    .i_shift     (w_shift),
    .i_bit       (in),
    .o_hist_next (w_hist_next),
    .o_fill_next (w_fill_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // cfg_load pre-empts the data bit presented in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_shift      = 1'b0;
    w_fill_clr   = 1'b0;
    w_match      = 1'b0;
    w_clr        = 1'b0;
    if (cfg_load) begin
      w_clr        = 1'b1;
      w_state_next = (w_len_clamped != '0) ? FILL : IDLE;
    end else begin
      case (r_state)
        FILL: begin
          if (in_valid) begin
            w_shift = 1'b1;
            if (w_fill_next >= r_len) begin
              w_state_next = ARMED;
              w_match      = w_hit;
              if (w_hit && !r_overlap) begin
                w_fill_clr   = 1'b1;
                w_state_next = FILL;
              end
            end
          end
        end
        ARMED: begin
          if (in_valid) begin
            w_shift = 1'b1;
            w_match = w_hit;
            if (w_hit && !r_overlap) begin
              w_fill_clr   = 1'b1;
              w_state_next = FILL;
            end
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat     <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_out     <= 1'b0;
      r_cnt     <= '0;
    end else if (cfg_load) begin
      r_pat     <= pat;
      r_len     <= w_len_clamped;
      r_overlap <= overlap;
      r_out     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_out <= w_match;
      if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign out       = r_out;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_param_sequence_detector.sv
// Directed bench for param_sequence_detector: expected pulses queued as bits are driven.
module tb_param_sequence_detector;

  logic       clk;
  logic       reset;
  logic       cfg_load;
  logic [7:0] pat;
  logic [3:0] pat_len;
  logic       overlap;
  logic       in_valid;
  logic       in_bit;
  logic       out0;
  logic [7:0] cnt0;
  logic       out1;
  logic [1:0] cnt1;

  int checks   = 0;
  int failures = 0;
  logic exp_q[$];

  param_sequence_detector #(.PAT_W(8), .CNT_W(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_load  (cfg_load),
    .pat       (pat),
    .pat_len   (pat_len),
    .overlap   (overlap),
    .in_valid  (in_valid),
    .in        (in_bit),
    .out       (out0),
    .match_cnt (cnt0)
  );

  param_sequence_detector #(.PAT_W(8), .CNT_W(2)) u_sat (
    .clk       (clk),
    .reset     (reset),
    .cfg_load  (cfg_load),
    .pat       (pat),
    .pat_len   (pat_len),
    .overlap   (overlap),
    .in_valid  (in_valid),
    .in        (in_bit),
    .out       (out1),
    .match_cnt (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop one expected out value per cycle, sampled just after the edge.
  always @(posedge clk) begin
    logic e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (out0 === e) else begin
        failures++;
        $error("FAIL out8: observed=%0b expected=%0b", out0, e);
      end
      checks++;
      assert (out1 === e) else begin
        failures++;
        $error("FAIL out2: observed=%0b expected=%0b", out1, e);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic cl, input logic v, input logic b, input logic e);
    @(negedge clk);
    cfg_load = cl;
    in_valid = v;
    in_bit   = b;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic v, input logic b);
    pat     = p;
    pat_len = l;
    overlap = o;
    step(1'b1, v, b, 1'b0);
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic b, input logic e);
    step(1'b0, 1'b1, b, e);
  endtask

  initial begin
    logic [7:0] s1;
    logic [6:0] e1;
    logic [7:0] a5;
    reset    = 1'b1;
    cfg_load = 1'b0;
    pat      = '0;
    pat_len  = '0;
    overlap  = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out", {31'd0, out0}, 32'd0);
    chk("rst_cnt", {24'd0, cnt0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Test 1: overlapping 1011 over 1,0,1,1,0,1,1.
    s1 = 8'b1011011_0;
    e1 = 7'b0001001;
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send(s1[7-i], e1[6-i]);
    chk("t1_cnt", {24'd0, cnt0}, 32'd2);

    // Test 2: non-overlapping, same stream.
    e1 = 7'b0001000;
    load(8'b0000_1011, 4'd4, 1'b0, 1'b0, 1'b0);
    chk("t2_cnt_clr", {24'd0, cnt0}, 32'd0);
    for (int i = 0; i < 7; i++) send(s1[7-i], e1[6-i]);
    chk("t2_cnt", {24'd0, cnt0}, 32'd1);

    // Test 3: in_valid gap between bits 2 and 3 is transparent.
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    chk("t3_cnt", {24'd0, cnt0}, 32'd2);

    // Test 4: 11 over six 1s; 2-bit counter saturates at 3.
    load(8'b0000_0011, 4'd2, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send(1'b1, 1'b1);
    chk("t4_cnt8", {24'd0, cnt0}, 32'd5);
    chk("t4_cnt2_sat", {30'd0, cnt1}, 32'd3);

    // Test 5: reset mid-pattern discards history and config.
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    exp_q.push_back(1'b0);
    @(posedge clk);
    #2;
    @(negedge clk);
    reset = 1'b0;
    send(1'b1, 1'b0);
    chk("t5_cnt", {24'd0, cnt0}, 32'd0);
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    chk("t5_relearn_cnt", {24'd0, cnt0}, 32'd1);

    // Test 6a: length 0 disables detection.
    load(8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) send(1'($urandom_range(0, 1)), 1'b0);
    chk("t6_len0_cnt", {24'd0, cnt0}, 32'd0);

    // Test 6b: full-width A5, then an over-range length that clamps to 8.
    a5 = 8'hA5;
    load(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send(a5[7-i], (i == 7));
    chk("t6_a5_cnt", {24'd0, cnt0}, 32'd1);
    load(8'hA5, 4'd12, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send(a5[7-i], 1'b0);
    send(a5[0], 1'b1);
    chk("t6_clamp_cnt", {24'd0, cnt0}, 32'd1);

    // Test 6c: bit presented with cfg_load is dropped.
    load(8'b0000_1011, 4'd4, 1'b1, 1'b1, 1'b1);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    chk("t6_cfgdrop_cnt", {24'd0, cnt0}, 32'd1);

    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
